ram_lsu: RTL and testbench

//  Load/store initiator for the CPU data path: drives the RAM port (addr, read strobe, write data, byte mask) and

---
 rtl/ram_lsu.sv | 158 +++++++++++++++
 tb/tb_ram_lsu.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu.sv
// ram_lsu: load/store initiator between the CPU data path and a synchronous RAM.
// Converts one RV32 load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into
// lane-aligned RAM strobes. Returns sign/zero-extended load data, or a
// misalignment/illegal-funct3 error.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     request handshake (ready only in IDLE)
//   req_we_i, req_funct3_i  store flag and RV32 funct3
//   req_addr_i, req_wdata_i byte address, right-justified store data
//   rsp_valid_o             one-cycle response pulse
//   rsp_rdata_o, rsp_err_o  extended load data / error flag (held until next response)
//   ram_addr_o, ram_rstb_o  RAM byte address and read strobe
//   ram_data_o, ram_mask_o  lane-replicated write data and byte write enables
//   ram_data_i              RAM read data, valid the cycle after the strobe
module ram_lsu #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rstb_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        ram_mask_o,
  input  logic [31:0]       ram_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RSP} state_t;

  state_t     state;
  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic        req_err;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_ready_o = (state == IDLE);

  // Request decode: alignment / legality check and store lane steering.
  always_comb begin
    req_err = 1'b0;
    st_data = req_wdata_i;
    st_mask = 4'b0000;
    case (req_funct3_i)
      3'd0, 3'd4: req_err = req_we_i && (req_funct3_i == 3'd4);
      3'd1, 3'd5: req_err = req_addr_i[0] || (req_we_i && (req_funct3_i == 3'd5));
      3'd2:       req_err = |req_addr_i[1:0];
      default:    req_err = 1'b1;
    endcase
    case (req_funct3_i[1:0])
      2'd0: begin
        st_data = {4{req_wdata_i[7:0]}};
        st_mask = 4'b0001 << req_addr_i[1:0];
      end
      2'd1: begin
        st_data = {2{req_wdata_i[15:0]}};
        st_mask = req_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = req_wdata_i;
        st_mask = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and extension, using the latched request.
  always_comb begin
    ld_byte = 8'h00;
    case (off_q)
      2'd0: ld_byte = ram_data_i[7:0];
      2'd1: ld_byte = ram_data_i[15:8];
      2'd2: ld_byte = ram_data_i[23:16];
      2'd3: ld_byte = ram_data_i[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = off_q[1] ? ram_data_i[31:16] : ram_data_i[15:0];
    case (f3_q[1:0])
      2'd0:    ld_data = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'd1:    ld_data = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_data = ram_data_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      ram_addr_o  <= '0;
      ram_rstb_o  <= 1'b0;
      ram_data_o  <= '0;
      ram_mask_o  <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q  <= req_we_i;
            f3_q  <= req_funct3_i;
            off_q <= req_addr_i[1:0];
            if (req_err) begin
              // Errors skip the RAM entirely and respond next cycle.
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
              rsp_valid_o <= 1'b1;
              state       <= RSP;
            end else begin
              ram_addr_o <= req_addr_i;
              ram_data_o <= st_data;
              ram_mask_o <= req_we_i ? st_mask : 4'b0000;
              ram_rstb_o <= ~req_we_i;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          ram_rstb_o <= 1'b0;
          ram_mask_o <= 4'b0000;
          if (we_q) begin
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_valid_o <= 1'b1;
            state       <= RSP;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= ld_data;
          rsp_valid_o <= 1'b1;
          state       <= RSP;
        end
        RSP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
module tb_ram_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = '0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [23:0] ram_addr;
  logic        ram_rstb;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_mask;
  logic [31:0] ram_rdata = '0;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    longint      t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_lsu #(.ADDR_W(24)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .ram_addr_o(ram_addr), .ram_rstb_o(ram_rstb), .ram_data_o(ram_wdata),
    .ram_mask_o(ram_mask), .ram_data_i(ram_rdata)
  );

  // Synchronous RAM: registered read, byte-masked write, no reset.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_rstb) ram_rdata <= mem[ram_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (ram_mask[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_latency", 32'(($time - e.t) / 10), 32'(e.lat));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Issue one request and check the RAM-side strobes; response goes via scoreboard.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [23:0] addr,
                        input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                        input logic [3:0] mask, input logic [31:0] wexp);
    exp_t e;
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
    e.err = err; e.rdata = rdata; e.lat = err ? 1 : (we ? 2 : 3); e.t = $time;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 24'hFFFFFF; req_wdata = 32'hDEADBEEF;
    if (err) begin
      chk("err_rstb", {31'd0, ram_rstb}, 32'd0);
      chk("err_mask", {28'd0, ram_mask}, 32'd0);
    end else begin
      chk("issue_rstb", {31'd0, ram_rstb}, {31'd0, ~we});
      chk("issue_mask", {28'd0, ram_mask}, {28'd0, mask});
      chk("issue_addr", {8'd0, ram_addr}, {8'd0, addr});
      if (we) chk("issue_data", ram_wdata, wexp);
    end
    @(negedge clk);
    chk("post_rstb", {31'd0, ram_rstb}, 32'd0);
    chk("post_mask", {28'd0, ram_mask}, 32'd0);
    wait_drain();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8] = 32'h80FF1234;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_ram_addr", {8'd0, ram_addr}, 32'd0);
    chk("rst_ram_data", ram_wdata, 32'd0);
    chk("rst_ram_mask", {28'd0, ram_mask}, 32'd0);
    chk("rst_ram_rstb", {31'd0, ram_rstb}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // Loads from word 0x20 = 0x80FF1234
    do_req(1'b0, 3'd0, 24'h23, 32'h0, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0); // LB
    do_req(1'b0, 3'd5, 24'h22, 32'h0, 1'b0, 32'h000080FF, 4'h0, 32'h0); // LHU
    do_req(1'b0, 3'd1, 24'h22, 32'h0, 1'b0, 32'hFFFF80FF, 4'h0, 32'h0); // LH
    do_req(1'b0, 3'd2, 24'h20, 32'h0, 1'b0, 32'h80FF1234, 4'h0, 32'h0); // LW
    do_req(1'b0, 3'd4, 24'h21, 32'h0, 1'b0, 32'h00000012, 4'h0, 32'h0); // LBU
    do_req(1'b0, 3'd0, 24'h20, 32'h0, 1'b0, 32'h00000034, 4'h0, 32'h0); // LB positive
    do_req(1'b0, 3'd1, 24'h20, 32'h0, 1'b0, 32'h00001234, 4'h0, 32'h0); // LH low half
    // Stores and read-back
    do_req(1'b1, 3'd2, 24'h14, 32'h45, 1'b0, 32'h0, 4'b1111, 32'h00000045);        // SW
    do_req(1'b0, 3'd2, 24'h14, 32'h0, 1'b0, 32'h00000045, 4'h0, 32'h0);
    do_req(1'b1, 3'd0, 24'h21, 32'h000000AB, 1'b0, 32'h0, 4'b0010, 32'hABABABAB);  // SB
    do_req(1'b0, 3'd2, 24'h20, 32'h0, 1'b0, 32'h80FFAB34, 4'h0, 32'h0);
    do_req(1'b1, 3'd1, 24'h2A, 32'h1234BEEF, 1'b0, 32'h0, 4'b1100, 32'hBEEFBEEF);  // SH
    do_req(1'b0, 3'd2, 24'h28, 32'h0, 1'b0, 32'hBEEF0000, 4'h0, 32'h0);
    // Errors
    do_req(1'b0, 3'd1, 24'h01, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);  // LH misaligned
    do_req(1'b1, 3'd2, 24'h06, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);  // SW misaligned
    do_req(1'b0, 3'd3, 24'h00, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);  // illegal load
    do_req(1'b1, 3'd4, 24'h00, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);  // illegal store
    // Error rsp_rdata/err hold after pulse
    chk("hold_err", {31'd0, rsp_err}, 32'd1);

    // Reset during RD_WAIT: no response for the aborted load
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'd2; req_addr = 24'h20;
    @(negedge clk);                 // ISSUE
    req_valid = 1'b0;
    @(negedge clk);                 // RD_WAIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_queue", 32'(sb.size()), 32'd0);
    do_req(1'b0, 3'd2, 24'h20, 32'h0, 1'b0, 32'h80FFAB34, 4'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
